// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//
// Instruction-decode stage of the 5-stage pipelined CPU. It decodes the
// instruction held in IF/ID, reads operands from the 32x32 register file
// (written back from WB), resolves EXE/MEM/WB forwarding and detects
// load-use hazards. On a hazard it raises stall and squashes the write
// controls so that ID/EXE receives a bubble. All id_* outputs are
// combinational and feed the ID/EXE register directly.
//
// Ports
//   clk, clr                    clock, synchronous active-high reset
//   inst                        instruction from IF/ID
//   wb_wreg/wb_rn/wb_data       register-file write port from WB
//   exe_wreg/exe_m2reg/exe_rn   EXE destination info, exe_alu its result
//   mem_wreg/mem_m2reg/mem_rn   MEM destination info, mem_alu / mem_mdata
//   id_m2reg,id_wmem,id_aluimm,
//   id_shift,id_wreg,id_aluc    decoded controls
//   id_ra, id_rb                forwarded rs / rt operands
//   id_imm                      sign- or zero-extended immediate
//   id_rn                       destination register
//   stall                       hold PC and IF/ID, bubble into ID/EXE
//   stall_cnt                   saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [31:0]            inst,
  input  logic                   wb_wreg,
  input  logic [4:0]             wb_rn,
  input  logic [31:0]            wb_data,
  input  logic                   exe_wreg,
  input  logic                   exe_m2reg,
  input  logic [4:0]             exe_rn,
  input  logic [31:0]            exe_alu,
  input  logic                   mem_wreg,
  input  logic                   mem_m2reg,
  input  logic [4:0]             mem_rn,
  input  logic [31:0]            mem_alu,
  input  logic [31:0]            mem_mdata,
  output logic                   id_m2reg,
  output logic                   id_wmem,
  output logic                   id_aluimm,
  output logic                   id_shift,
  output logic                   id_wreg,
  output logic [2:0]             id_aluc,
  output logic [31:0]            id_ra,
  output logic [31:0]            id_rb,
  output logic [31:0]            id_imm,
  output logic [4:0]             id_rn,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_LUI = 3'b111;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  logic        dec_wreg;
  logic        dec_m2reg;
  logic        dec_wmem;
  logic        dec_aluimm;
  logic        dec_shift;
  logic        dec_sext;
  logic [2:0]  dec_aluc;
  logic [4:0]  dec_rn;
  logic        use_rs;
  logic        use_rt;

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  logic [31:0] rs_rf;
  logic [31:0] rt_rf;
  logic        load_use;

  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];

  // Instruction decode. Anything not recognised falls through to the
  // defaults, which form a NOP that uses no sources, so it can never stall.
  always_comb begin
    dec_wreg   = 1'b0;
    dec_m2reg  = 1'b0;
    dec_wmem   = 1'b0;
    dec_aluimm = 1'b0;
    dec_shift  = 1'b0;
    dec_sext   = 1'b1;
    dec_aluc   = ALU_ADD;
    dec_rn     = 5'd0;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR: begin
            dec_wreg = 1'b1;
            dec_rn   = rd;
            use_rs   = 1'b1;
            use_rt   = 1'b1;
            unique case (funct)
              FN_SUB:  dec_aluc = ALU_SUB;
              FN_AND:  dec_aluc = ALU_AND;
              FN_OR:   dec_aluc = ALU_OR;
              default: dec_aluc = ALU_ADD;
            endcase
          end
          // Shifts take shamt through id_imm[10:6], so rs is not a source.
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_wreg  = 1'b1;
            dec_shift = 1'b1;
            dec_rn    = rd;
            use_rt    = 1'b1;
            unique case (funct)
              FN_SRL:  dec_aluc = ALU_SRL;
              FN_SRA:  dec_aluc = ALU_SRA;
              default: dec_aluc = ALU_SLL;
            endcase
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        dec_wreg   = 1'b1;
        dec_aluimm = 1'b1;
        dec_rn     = rt;
        use_rs     = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        dec_wreg   = 1'b1;
        dec_aluimm = 1'b1;
        dec_sext   = 1'b0;
        dec_aluc   = (op == OP_ANDI) ? ALU_AND : ALU_OR;
        dec_rn     = rt;
        use_rs     = 1'b1;
      end
      OP_LUI: begin
        dec_wreg   = 1'b1;
        dec_aluimm = 1'b1;
        dec_sext   = 1'b0;
        dec_aluc   = ALU_LUI;
        dec_rn     = rt;
      end
      OP_LW: begin
        dec_wreg   = 1'b1;
        dec_m2reg  = 1'b1;
        dec_aluimm = 1'b1;
        dec_rn     = rt;
        use_rs     = 1'b1;
      end
      // Stores read rt as the data to write to memory.
      OP_SW: begin
        dec_wmem   = 1'b1;
        dec_aluimm = 1'b1;
        dec_rn     = rt;
        use_rs     = 1'b1;
        use_rt     = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file update. r0 is hardwired to zero, so writes to it are
  // dropped here rather than masked on every read.
  always_comb begin
    rf_d = rf_q;
    if (wb_wreg && (wb_rn != 5'd0)) begin
      rf_d[wb_rn] = wb_data;
    end
  end

  // Stall counter saturates instead of wrapping so a long hazard run
  // cannot masquerade as a short one.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      rf_q        <= rf_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Register-file read with write-through, so an instruction in ID sees a
  // value being written back in the same cycle.
  always_comb begin
    rs_rf = rf_q[rs];
    rt_rf = rf_q[rt];
    if (wb_wreg && (wb_rn != 5'd0) && (wb_rn == rs)) begin
      rs_rf = wb_data;
    end
    if (wb_wreg && (wb_rn != 5'd0) && (wb_rn == rt)) begin
      rt_rf = wb_data;
    end
  end

  // Forwarding, youngest producer first. A load in EXE has no data yet,
  // so it is skipped here and handled by the load-use stall instead.
  always_comb begin
    id_ra = rs_rf;
    if (exe_wreg && !exe_m2reg && (exe_rn == rs) && (rs != 5'd0)) begin
      id_ra = exe_alu;
    end else if (mem_wreg && (mem_rn == rs) && (rs != 5'd0)) begin
      id_ra = mem_m2reg ? mem_mdata : mem_alu;
    end

    id_rb = rt_rf;
    if (exe_wreg && !exe_m2reg && (exe_rn == rt) && (rt != 5'd0)) begin
      id_rb = exe_alu;
    end else if (mem_wreg && (mem_rn == rt) && (rt != 5'd0)) begin
      id_rb = mem_m2reg ? mem_mdata : mem_alu;
    end
  end

  // Only sources the instruction really reads may cause a stall.
  assign load_use = exe_wreg && exe_m2reg && (exe_rn != 5'd0) &&
                    ((use_rs && (exe_rn == rs)) || (use_rt && (exe_rn == rt)));

  assign stall = load_use && !clr;

  // A stalled or reset instruction becomes a bubble: its side-effect
  // controls are cleared, while the rest of the decode passes through.
  assign id_wreg   = dec_wreg  && !stall && !clr;
  assign id_wmem   = dec_wmem  && !stall && !clr;
  assign id_m2reg  = dec_m2reg && !stall && !clr;
  assign id_aluimm = dec_aluimm;
  assign id_shift  = dec_shift;
  assign id_aluc   = dec_aluc;
  assign id_rn     = dec_rn;
  assign id_imm    = dec_sext ? {{16{inst[15]}}, inst[15:0]} : {16'h0000, inst[15:0]};
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
//
// Directed self-checking bench for id_stage. Inputs change on the falling
// edge and outputs are sampled 2 ns later, well clear of the rising edge
// where the register file and stall counter update.
// ---------------------------------------------------------------------------
module tb_id_stage;

  logic        clk;
  logic        clr;
  logic [31:0] inst;
  logic        wb_wreg;
  logic [4:0]  wb_rn;
  logic [31:0] wb_data;
  logic        exe_wreg;
  logic        exe_m2reg;
  logic [4:0]  exe_rn;
  logic [31:0] exe_alu;
  logic        mem_wreg;
  logic        mem_m2reg;
  logic [4:0]  mem_rn;
  logic [31:0] mem_alu;
  logic [31:0] mem_mdata;
  logic        id_m2reg;
  logic        id_wmem;
  logic        id_aluimm;
  logic        id_shift;
  logic        id_wreg;
  logic [2:0]  id_aluc;
  logic [31:0] id_ra;
  logic [31:0] id_rb;
  logic [31:0] id_imm;
  logic [4:0]  id_rn;
  logic        stall;
  logic [15:0] stall_cnt;

  int checks;
  int errors;

  id_stage #(.STALL_CNT_W(16)) dut (
    .clk       (clk),
    .clr       (clr),
    .inst      (inst),
    .wb_wreg   (wb_wreg),
    .wb_rn     (wb_rn),
    .wb_data   (wb_data),
    .exe_wreg  (exe_wreg),
    .exe_m2reg (exe_m2reg),
    .exe_rn    (exe_rn),
    .exe_alu   (exe_alu),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .mem_alu   (mem_alu),
    .mem_mdata (mem_mdata),
    .id_m2reg  (id_m2reg),
    .id_wmem   (id_wmem),
    .id_aluimm (id_aluimm),
    .id_shift  (id_shift),
    .id_wreg   (id_wreg),
    .id_aluc   (id_aluc),
    .id_ra     (id_ra),
    .id_rb     (id_rb),
    .id_imm    (id_imm),
    .id_rn     (id_rn),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Puts every pipeline-side input into a quiet state.
  task automatic set_idle();
    wb_wreg   = 1'b0; wb_rn  = 5'd0; wb_data   = 32'h0;
    exe_wreg  = 1'b0; exe_m2reg = 1'b0; exe_rn = 5'd0; exe_alu = 32'h0;
    mem_wreg  = 1'b0; mem_m2reg = 1'b0; mem_rn = 5'd0;
    mem_alu   = 32'h0; mem_mdata = 32'h0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    set_idle();
    inst = 32'h0;
    @(negedge clk);
    // Load hazard on r1 present while clr is high must not stall.
    inst = 32'h00221820;
    exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = 5'd1;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %0b expected 0", stall); end
    checks++; if (id_wreg !== 1'b0) begin errors++; $display("[TB] FAIL reset_wreg got %0b expected 0", id_wreg); end
    @(negedge clk);
    clr = 1'b0;
    set_idle();
    #2;
    checks++; if (id_ra !== 32'h0) begin errors++; $display("[TB] FAIL reset_ra got %h expected 0", id_ra); end
    checks++; if (id_rb !== 32'h0) begin errors++; $display("[TB] FAIL reset_rb got %h expected 0", id_rb); end
    checks++; if (id_rn !== 5'd3) begin errors++; $display("[TB] FAIL reset_rn got %0d expected 3", id_rn); end
    checks++; if (id_wreg !== 1'b1) begin errors++; $display("[TB] FAIL reset_add_wreg got %0b expected 1", id_wreg); end
    checks++; if (id_aluc !== 3'b000) begin errors++; $display("[TB] FAIL reset_aluc got %b expected 000", id_aluc); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall2 got %0b expected 0", stall); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_stall_cnt got %h expected 0", stall_cnt); end
  endtask

  task automatic test_regfile();
    @(negedge clk);
    inst = 32'h0;
    wb_wreg = 1'b1; wb_rn = 5'd1; wb_data = 32'h11;
    @(negedge clk);
    wb_rn = 5'd2; wb_data = 32'h22;
    @(negedge clk);
    // r2 is being rewritten this cycle: write-through must win.
    wb_rn = 5'd2; wb_data = 32'h99;
    inst = 32'h00221820;
    #2;
    checks++; if (id_ra !== 32'h11) begin errors++; $display("[TB] FAIL rf_ra got %h expected 11", id_ra); end
    checks++; if (id_rb !== 32'h99) begin errors++; $display("[TB] FAIL rf_wt_rb got %h expected 99", id_rb); end
    @(negedge clk);
    wb_rn = 5'd0; wb_data = 32'hDEAD;
    inst = 32'h00011820;
    #2;
    checks++; if (id_ra !== 32'h0) begin errors++; $display("[TB] FAIL rf_r0_wt got %h expected 0", id_ra); end
    checks++; if (id_rb !== 32'h11) begin errors++; $display("[TB] FAIL rf_r1 got %h expected 11", id_rb); end
    @(negedge clk);
    wb_wreg = 1'b0;
    #2;
    checks++; if (id_ra !== 32'h0) begin errors++; $display("[TB] FAIL rf_r0 got %h expected 0", id_ra); end
    @(negedge clk);
    inst = 32'h00221820;
    #2;
    checks++; if (id_rb !== 32'h99) begin errors++; $display("[TB] FAIL rf_r2 got %h expected 99", id_rb); end
    @(negedge clk);
    wb_wreg = 1'b1; wb_rn = 5'd3; wb_data = 32'h33;
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    inst = 32'h20A6FFFF;
    exe_wreg = 1'b1; exe_m2reg = 1'b0; exe_rn = 5'd5; exe_alu = 32'hA;
    mem_wreg = 1'b1; mem_m2reg = 1'b0; mem_rn = 5'd5; mem_alu = 32'hB;
    wb_wreg  = 1'b1; wb_rn = 5'd5; wb_data = 32'hC;
    #2;
    checks++; if (id_ra !== 32'hA) begin errors++; $display("[TB] FAIL fwd_exe got %h expected a", id_ra); end
    checks++; if (id_imm !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL addi_imm got %h expected ffffffff", id_imm); end
    checks++; if (id_rn !== 5'd6) begin errors++; $display("[TB] FAIL addi_rn got %0d expected 6", id_rn); end
    checks++; if (id_aluimm !== 1'b1) begin errors++; $display("[TB] FAIL addi_aluimm got %0b expected 1", id_aluimm); end
    @(negedge clk);
    exe_wreg = 1'b0;
    #2;
    checks++; if (id_ra !== 32'hB) begin errors++; $display("[TB] FAIL fwd_mem_alu got %h expected b", id_ra); end
    @(negedge clk);
    mem_m2reg = 1'b1; mem_mdata = 32'hD;
    #2;
    checks++; if (id_ra !== 32'hD) begin errors++; $display("[TB] FAIL fwd_mem_data got %h expected d", id_ra); end
    @(negedge clk);
    mem_wreg = 1'b0;
    #2;
    checks++; if (id_ra !== 32'hC) begin errors++; $display("[TB] FAIL fwd_wb got %h expected c", id_ra); end
    @(negedge clk);
    set_idle();
    #2;
    checks++; if (id_ra !== 32'hC) begin errors++; $display("[TB] FAIL fwd_rf got %h expected c", id_ra); end
  endtask

  task automatic test_decode();
    @(negedge clk);
    inst = 32'h00031100;
    #2;
    checks++; if (id_shift !== 1'b1) begin errors++; $display("[TB] FAIL sll_shift got %0b expected 1", id_shift); end
    checks++; if (id_imm[10:6] !== 5'd4) begin errors++; $display("[TB] FAIL sll_shamt got %0d expected 4", id_imm[10:6]); end
    checks++; if (id_aluc !== 3'b100) begin errors++; $display("[TB] FAIL sll_aluc got %b expected 100", id_aluc); end
    checks++; if (id_rb !== 32'h33) begin errors++; $display("[TB] FAIL sll_rb got %h expected 33", id_rb); end
    checks++; if (id_rn !== 5'd2) begin errors++; $display("[TB] FAIL sll_rn got %0d expected 2", id_rn); end
    @(negedge clk);
    inst = 32'h00031103;
    #2;
    checks++; if (id_aluc !== 3'b110) begin errors++; $display("[TB] FAIL sra_aluc got %b expected 110", id_aluc); end
    @(negedge clk);
    inst = 32'hFC000000;
    #2;
    checks++; if ({id_wreg, id_wmem, id_m2reg} !== 3'b000) begin errors++; $display("[TB] FAIL illegal_op got %b expected 000", {id_wreg, id_wmem, id_m2reg}); end
    checks++; if ({id_aluimm, id_shift, id_aluc} !== 5'b00000) begin errors++; $display("[TB] FAIL illegal_op_ctl got %b expected 00000", {id_aluimm, id_shift, id_aluc}); end
    @(negedge clk);
    inst = 32'h0022182A;
    #2;
    checks++; if (id_wreg !== 1'b0) begin errors++; $display("[TB] FAIL illegal_funct got %0b expected 0", id_wreg); end
    @(negedge clk);
    inst = 32'h8C280004;
    #2;
    checks++; if ({id_wreg, id_m2reg, id_wmem, id_aluimm} !== 4'b1101) begin errors++; $display("[TB] FAIL lw_ctl got %b expected 1101", {id_wreg, id_m2reg, id_wmem, id_aluimm}); end
    checks++; if (id_ra !== 32'h11) begin errors++; $display("[TB] FAIL lw_ra got %h expected 11", id_ra); end
    checks++; if (id_rn !== 5'd8) begin errors++; $display("[TB] FAIL lw_rn got %0d expected 8", id_rn); end
    @(negedge clk);
    inst = 32'h30298000;
    #2;
    checks++; if (id_imm !== 32'h00008000) begin errors++; $display("[TB] FAIL andi_zext got %h expected 00008000", id_imm); end
    checks++; if (id_aluc !== 3'b010) begin errors++; $display("[TB] FAIL andi_aluc got %b expected 010", id_aluc); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    inst = 32'hACE40000;
    exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = 5'd4;
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_rt_stall got %0b expected 1", stall); end
    checks++; if (id_wmem !== 1'b0) begin errors++; $display("[TB] FAIL lu_wmem got %0b expected 0", id_wmem); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL lu_cnt0 got %0d expected 0", stall_cnt); end
    @(negedge clk);
    inst = 32'h3C041234;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lui_nostall got %0b expected 0", stall); end
    checks++; if (id_imm !== 32'h00001234) begin errors++; $display("[TB] FAIL lui_imm got %h expected 00001234", id_imm); end
    checks++; if (id_aluc !== 3'b111) begin errors++; $display("[TB] FAIL lui_aluc got %b expected 111", id_aluc); end
    checks++; if (id_wreg !== 1'b1) begin errors++; $display("[TB] FAIL lui_wreg got %0b expected 1", id_wreg); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL lu_cnt1 got %0d expected 1", stall_cnt); end
    @(negedge clk);
    inst = 32'hACE40000;
    exe_rn = 5'd7;
    #2;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_rs_stall got %0b expected 1", stall); end
    @(negedge clk);
    exe_wreg = 1'b0; exe_m2reg = 1'b0; exe_rn = 5'd0;
    mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rn = 5'd4; mem_mdata = 32'h44;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_after_stall got %0b expected 0", stall); end
    checks++; if (id_wmem !== 1'b1) begin errors++; $display("[TB] FAIL lu_after_wmem got %0b expected 1", id_wmem); end
    checks++; if (id_rb !== 32'h44) begin errors++; $display("[TB] FAIL lu_after_rb got %h expected 44", id_rb); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("[TB] FAIL lu_cnt2 got %0d expected 2", stall_cnt); end
    @(negedge clk);
    set_idle();
    exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = 5'd0;
    inst = 32'h00011820;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_r0 got %0b expected 0", stall); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    set_idle();
    inst = 32'hACE40000;
    exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = 5'd4;
    repeat (65539) @(negedge clk);
    #2;
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_cnt got %h expected ffff", stall_cnt); end
    clr = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL clr_stall got %0b expected 0", stall); end
    checks++; if ({id_wreg, id_wmem, id_m2reg} !== 3'b000) begin errors++; $display("[TB] FAIL clr_ctl got %b expected 000", {id_wreg, id_wmem, id_m2reg}); end
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL clr_sync got %h expected ffff", stall_cnt); end
    @(negedge clk);
    clr = 1'b0;
    #2;
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("[TB] FAIL clr_cnt got %h expected 0", stall_cnt); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL clr_resume got %0b expected 1", stall); end
    @(negedge clk);
    set_idle();
    inst = 32'h00221820;
    #2;
    checks++; if ({id_ra, id_rb} !== 64'h0) begin errors++; $display("[TB] FAIL clr_r1r2 got %h expected 0", {id_ra, id_rb}); end
    @(negedge clk);
    inst = 32'h00031100;
    #2;
    checks++; if (id_rb !== 32'h0) begin errors++; $display("[TB] FAIL clr_r3 got %h expected 0", id_rb); end
    @(negedge clk);
    inst = 32'h20A6FFFF;
    #2;
    checks++; if (id_ra !== 32'h0) begin errors++; $display("[TB] FAIL clr_r5 got %h expected 0", id_ra); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b1;
    inst = 32'h0;
    set_idle();
    test_reset();
    test_regfile();
    test_forwarding();
    test_decode();
    test_load_use();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
